// File: rtl/ws2812_frame_ctrl.sv
// Double-buffered WS2812 frame controller: two requesters write a shadow frame
// under round-robin arbitration, and the frame is swapped to the driver at refresh-slot boundaries.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS     = 8,
    parameter int FRAME_CYCLES = 6500,
    localparam int AW          = $clog2(NUM_LEDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr0_valid,
    output logic                  wr0_ready,
    input  logic [AW-1:0]         wr0_addr,
    input  logic [23:0]           wr0_rgb,
    input  logic                  wr0_last,
    input  logic                  wr1_valid,
    output logic                  wr1_ready,
    input  logic [AW-1:0]         wr1_addr,
    input  logic [23:0]           wr1_rgb,
    input  logic                  wr1_last,
    output logic [24*NUM_LEDS-1:0] packed_rgb_data,
    output logic                  drv_reset,
    output logic                  swap_pending,
    output logic                  addr_err,
    output logic [15:0]           frame_count,
    output logic [1:0]            dbg_state_o
);
    // Handshake: a beat transfers on a rising edge where valid && ready; ready is
    // combinational, never high for both requesters, and independent of the beat payload.
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_CYCLES - 1);
    localparam logic [AW:0] NL = (AW + 1)'(NUM_LEDS);

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic [24*NUM_LEDS-1:0]  shadow_q, shadow_d;
    logic [24*NUM_LEDS-1:0]  active_q, active_d;
    logic                    pend_q, pend_d;
    logic                    err_q, err_d;
    logic [15:0]             fc_q, fc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    drv_q, drv_d;

    logic          acc0, acc1, wr_en, commit, in_range, boundary, swap;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_rgb;

    always_comb begin
        wr0_ready = 1'b0;
        wr1_ready = 1'b0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        if (!reset) begin
            case (state_q)
                // ptr_q names the requester granted last; the other one wins a tie
                IDLE: begin
                    if (wr0_valid && (!wr1_valid || ptr_q)) wr0_ready = 1'b1;
                    else if (wr1_valid)                     wr1_ready = 1'b1;
                end
                OWN0:    wr0_ready = 1'b1;
                OWN1:    wr1_ready = 1'b1;
                default: ;
            endcase
        end
        acc0 = wr0_valid && wr0_ready;
        acc1 = wr1_valid && wr1_ready;
        if (acc0) begin
            state_d = wr0_last ? IDLE : OWN0;
            if (wr0_last) ptr_d = 1'b0;
        end else if (acc1) begin
            state_d = wr1_last ? IDLE : OWN1;
            if (wr1_last) ptr_d = 1'b1;
        end
    end

    always_comb begin
        wr_en    = acc0 || acc1;
        wr_addr  = acc1 ? wr1_addr : wr0_addr;
        wr_rgb   = acc1 ? wr1_rgb  : wr0_rgb;
        commit   = (acc0 && wr0_last) || (acc1 && wr1_last);
        in_range = {1'b0, wr_addr} < NL;
        shadow_d = shadow_q;
        if (wr_en && in_range) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_addr == AW'(i)) shadow_d[24*i +: 24] = wr_rgb;
            end
        end
        err_d    = err_q || (wr_en && !in_range);
        boundary = (cnt_q == '0);
        cnt_d    = boundary ? CNT_MAX : cnt_q - CW'(1);
        // Swap copies the pre-write shadow; a commit in the same cycle re-arms pending
        swap     = boundary && pend_q;
        pend_d   = commit ? 1'b1 : (swap ? 1'b0 : pend_q);
        active_d = swap ? shadow_q : active_q;
        fc_d     = swap ? fc_q + 16'd1 : fc_q;
        drv_d    = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b1;
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            fc_q     <= 16'd0;
            cnt_q    <= CNT_MAX;
            drv_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            fc_q     <= fc_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
        end
    end

    assign packed_rgb_data = active_q;
    assign drv_reset       = drv_q;
    assign swap_pending    = pend_q;
    assign addr_err        = err_q;
    assign frame_count     = fc_q;
    assign dbg_state_o     = state_q;
endmodule
